// File: rtl/lfsr_tx_pkg.sv
// Shared definitions for the LFSR result UART transmitter: TX state
// encodings, UART line levels and a constant-friendly ceil(log2) helper.
package lfsr_tx_pkg;

    localparam logic [2:0] TX_IDLE   = 3'd0;
    localparam logic [2:0] TX_START  = 3'd1;
    localparam logic [2:0] TX_DATA   = 3'd2;
    localparam logic [2:0] TX_PARITY = 3'd3;
    localparam logic [2:0] TX_STOP   = 3'd4;

    localparam logic UART_IDLE_LEVEL = 1'b1;
    localparam logic START_BIT       = 1'b0;

    // Smallest r with 2**r >= value; usable in parameter expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/lfsr_result_fifo.sv
// Small circular result buffer between the capture logic and the UART
// shifter. A write that arrives while full is dropped unless a read
// frees a slot in the same cycle; any drop sets a sticky overflow flag
// that only reset clears.
module lfsr_result_fifo
    import lfsr_tx_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_en,
    output logic [DWIDTH-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic              overflow
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_write;
    logic              do_read;
    logic              drop;

    assign empty    = (count == '0);
    assign full     = (count == CNT_FULL);
    assign do_read  = rd_en & ~empty;
    assign do_write = wr_en & (~full | do_read);
    assign drop     = wr_en & full & ~do_read;
    assign rd_data  = mem[rd_ptr];

    // Storage needs no reset: an empty count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_read) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_write, do_read})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Remember that at least one result was lost since reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/lfsr_result_uart_tx.sv
// Captures each finished LFSR result on the falling edge of the
// generator's busy flag, queues it, and sends it off-chip as a UART
// frame (start, DWIDTH data bits LSB first, stop).
// Optional feature macro: LFSR_TX_PARITY_EN adds an even parity bit
// between the data bits and the stop bit.
module lfsr_result_uart_tx
    import lfsr_tx_pkg::*;
#(
    parameter int DWIDTH       = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [DWIDTH-1:0] num_i,
    input  logic              busy_i,
    output logic              tx_o,
    output logic              tx_active_o,
    output logic              fifo_full_o,
    output logic              overflow_o
);

    localparam int BAUD_W = clog2(CLKS_PER_BIT);
    localparam int BIT_W  = (DWIDTH > 1) ? clog2(DWIDTH) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DWIDTH - 1);

    logic              busy_q;
    logic              cap;
    logic              pop;
    logic              fifo_empty;
    logic [DWIDTH-1:0] fifo_data;
    logic [2:0]        state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DWIDTH-1:0] shift_reg;
    logic              baud_done;
`ifdef LFSR_TX_PARITY_EN
    logic              parity_bit;
`endif

    assign cap       = busy_q & ~busy_i;
    assign pop       = (state == TX_IDLE) & ~fifo_empty;
    assign baud_done = (baud_cnt == BAUD_LAST);

    // Delayed copy of busy so a high-to-low transition can be spotted.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= busy_i;
        end
    end

    lfsr_result_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_i),
        .wr_en    (cap),
        .wr_data  (num_i),
        .rd_en    (pop),
        .rd_data  (fifo_data),
        .empty    (fifo_empty),
        .full     (fifo_full_o),
        .overflow (overflow_o)
    );

    // Frame sequencer: the result is copied into a private shift register
    // on pop, so FIFO traffic during a frame cannot disturb it.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state      <= TX_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
`ifdef LFSR_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                TX_IDLE: begin
                    if (!fifo_empty) begin
                        state      <= TX_START;
                        shift_reg  <= fifo_data;
                        baud_cnt   <= '0;
                        bit_cnt    <= '0;
`ifdef LFSR_TX_PARITY_EN
                        parity_bit <= ^fifo_data;
`endif
                    end
                end
                TX_START: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        state    <= TX_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (baud_done) begin
                        baud_cnt  <= '0;
                        shift_reg <= shift_reg >> 1;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
`ifdef LFSR_TX_PARITY_EN
                            state   <= TX_PARITY;
`else
                            state   <= TX_STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef LFSR_TX_PARITY_EN
                TX_PARITY: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        state    <= TX_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                TX_STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        state    <= TX_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= TX_IDLE;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                end
            endcase
        end
    end

    // Line level and activity flag follow the state directly, so reset
    // returns the line to idle without waiting for a clock.
    always_comb begin
        tx_o        = UART_IDLE_LEVEL;
        tx_active_o = 1'b0;
        case (state)
            TX_START: begin
                tx_o        = START_BIT;
                tx_active_o = 1'b1;
            end
            TX_DATA: begin
                tx_o        = shift_reg[0];
                tx_active_o = 1'b1;
            end
`ifdef LFSR_TX_PARITY_EN
            TX_PARITY: begin
                tx_o        = parity_bit;
                tx_active_o = 1'b1;
            end
`endif
            TX_STOP: begin
                tx_o        = UART_IDLE_LEVEL;
                tx_active_o = 1'b1;
            end
            default: begin
                tx_o        = UART_IDLE_LEVEL;
                tx_active_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_lfsr_result_uart_tx.sv
// Bench for lfsr_result_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4). A line
// monitor decodes frames from tx_o into queues; each test task compares
// those against the values it captured, in order.
// Optional feature macro: LFSR_TX_PARITY_EN.
module tb_lfsr_result_uart_tx;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CPB   = 4;
`ifdef LFSR_TX_PARITY_EN
    localparam int FRAME_BITS = DW + 3;
`else
    localparam int FRAME_BITS = DW + 2;
`endif
    localparam int FRAME_CLKS = FRAME_BITS * CPB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] num_i;
    logic          busy_i;
    logic          tx_o;
    logic          tx_active_o;
    logic          fifo_full_o;
    logic          overflow_o;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Monitor state and decoded frames
    bit            mon_in_frame = 1'b0;
    int            mon_idx = 0;
    int            mon_bit;
    int            mon_pos;
    logic [DW-1:0] mon_data = '0;
    logic          mon_par = 1'b0;
    int            line_errs = 0;
    logic [DW-1:0] rx_q[$];
    logic          par_q[$];
    int            start_q[$];
    int            end_q[$];

    lfsr_result_uart_tx #(
        .DWIDTH       (DW),
        .FIFO_DEPTH   (DEPTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst_n),
        .num_i       (num_i),
        .busy_i      (busy_i),
        .tx_o        (tx_o),
        .tx_active_o (tx_active_o),
        .fifo_full_o (fifo_full_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // UART receiver: every bit must hold one level for CPB samples,
    // start low, stop high, and tx_active_o high exactly inside frames.
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            mon_in_frame = 1'b0;
        end else begin
            if (!mon_in_frame) begin
                if (tx_o === 1'b0) begin
                    mon_in_frame = 1'b1;
                    mon_idx = 0;
                    start_q.push_back(cyc);
                end else if (tx_o !== 1'b1 || tx_active_o !== 1'b0) begin
                    line_errs++;
                end
            end
            if (mon_in_frame) begin
                mon_bit = mon_idx / CPB;
                mon_pos = mon_idx % CPB;
                if (tx_active_o !== 1'b1) line_errs++;
                if (mon_bit == 0) begin
                    if (tx_o !== 1'b0) line_errs++;
                end else if (mon_bit <= DW) begin
                    if (mon_pos == 0) mon_data[mon_bit-1] = tx_o;
                    else if (tx_o !== mon_data[mon_bit-1]) line_errs++;
                end else if (mon_bit == FRAME_BITS - 1) begin
                    if (tx_o !== 1'b1) line_errs++;
                end else begin
                    if (mon_pos == 0) mon_par = tx_o;
                    else if (tx_o !== mon_par) line_errs++;
                end
                mon_idx++;
                if (mon_idx == FRAME_CLKS) begin
                    rx_q.push_back(mon_data);
                    par_q.push_back(mon_par);
                    end_q.push_back(cyc);
                    mon_in_frame = 1'b0;
                end
            end
        end
    end

    // One generator result: busy high for a cycle, then low with the value;
    // capture happens on the last edge inside this task.
    task automatic pulse(input logic [DW-1:0] v);
        busy_i = 1'b1;
        num_i  = DW'($urandom);
        @(posedge clk); #1;
        busy_i = 1'b0;
        num_i  = v;
        @(posedge clk); #1;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k;
        k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic clear_mon();
        rx_q.delete();
        par_q.delete();
        start_q.delete();
        end_q.delete();
        line_errs = 0;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        busy_i = 1'b0;
        num_i  = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (tx_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx: got %b exp 1", tx_o); end
        checks++; if (tx_active_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_active: got %b exp 0", tx_active_o); end
        checks++; if (fifo_full_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %b exp 0", fifo_full_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b exp 0", overflow_o); end
        @(negedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (tx_o !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_tx: got %b exp 1", tx_o); end
        checks++; if (tx_active_o !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_active: got %b exp 0", tx_active_o); end
    endtask

    task automatic test_single();
        int cap_cyc;
        clear_mon();
        pulse(8'hA5);
        cap_cyc = cyc;
        wait_frames(1, FRAME_CLKS + 20);
        checks++; if (rx_q.size() != 1) begin errors++; $display("[TB] FAIL single_count: got %0d exp 1", rx_q.size()); end
        if (rx_q.size() >= 1) begin
            checks++; if (rx_q[0] !== 8'hA5) begin errors++; $display("[TB] FAIL single_data: got %h exp a5", rx_q[0]); end
            checks++; if (start_q[0] != cap_cyc + 1) begin errors++; $display("[TB] FAIL single_latency: start %0d exp %0d", start_q[0], cap_cyc + 1); end
            checks++; if (end_q[0] - start_q[0] + 1 != FRAME_CLKS) begin errors++; $display("[TB] FAIL single_length: got %0d exp %0d", end_q[0] - start_q[0] + 1, FRAME_CLKS); end
`ifdef LFSR_TX_PARITY_EN
            checks++; if (par_q[0] !== 1'b0) begin errors++; $display("[TB] FAIL single_parity: got %b exp 0", par_q[0]); end
`endif
        end
        checks++; if (tx_active_o !== 1'b0) begin errors++; $display("[TB] FAIL single_active_after: got %b exp 0", tx_active_o); end
        checks++; if (line_errs != 0) begin errors++; $display("[TB] FAIL single_line: got %0d bad samples exp 0", line_errs); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_q[$];
        clear_mon();
        exp_q = '{8'h01, 8'h80, 8'hFF};
        foreach (exp_q[i]) pulse(exp_q[i]);
        wait_frames(3, 3 * (FRAME_CLKS + 1) + 40);
        checks++; if (rx_q.size() != 3) begin errors++; $display("[TB] FAIL b2b_count: got %0d exp 3", rx_q.size()); end
        for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL b2b_data%0d: got %h exp %h", i, rx_q[i], exp_q[i]); end
        end
        for (int i = 0; i + 1 < start_q.size() && i < end_q.size(); i++) begin
            checks++; if (start_q[i+1] - end_q[i] != 2) begin errors++; $display("[TB] FAIL b2b_gap%0d: got %0d idle clocks exp 1", i, start_q[i+1] - end_q[i] - 1); end
        end
        checks++; if (line_errs != 0) begin errors++; $display("[TB] FAIL b2b_line: got %0d bad samples exp 0", line_errs); end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] v;
        clear_mon();
        for (int i = 0; i < 6; i++) begin
            v = DW'($urandom);
            pulse(v);
            if (i < 5) exp_q.push_back(v);
            if (i == 4) begin
                checks++; if (fifo_full_o !== 1'b1) begin errors++; $display("[TB] FAIL ovf_full: got %b exp 1", fifo_full_o); end
                checks++; if (overflow_o !== 1'b0) begin errors++; $display("[TB] FAIL ovf_early: got %b exp 0", overflow_o); end
            end
        end
        checks++; if (overflow_o !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set: got %b exp 1", overflow_o); end
        wait_frames(5, 5 * (FRAME_CLKS + 1) + 40);
        repeat (3 * FRAME_CLKS) @(posedge clk);
        #1;
        checks++; if (rx_q.size() != 5) begin errors++; $display("[TB] FAIL ovf_count: got %0d exp 5", rx_q.size()); end
        for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL ovf_data%0d: got %h exp %h", i, rx_q[i], exp_q[i]); end
        end
        checks++; if (overflow_o !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %b exp 1", overflow_o); end
        checks++; if (fifo_full_o !== 1'b0) begin errors++; $display("[TB] FAIL ovf_drained: got %b exp 0", fifo_full_o); end
        checks++; if (line_errs != 0) begin errors++; $display("[TB] FAIL ovf_line: got %0d bad samples exp 0", line_errs); end
    endtask

    task automatic test_no_capture();
        clear_mon();
        for (int i = 0; i < 8; i++) begin
            num_i = DW'($urandom);
            @(posedge clk); #1;
        end
        busy_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            num_i = DW'($urandom);
            @(posedge clk); #1;
        end
        repeat (4) @(posedge clk);
        #1;
        checks++; if (start_q.size() != 0) begin errors++; $display("[TB] FAIL nocap_frames: got %0d exp 0", start_q.size()); end
        checks++; if (tx_active_o !== 1'b0) begin errors++; $display("[TB] FAIL nocap_active: got %b exp 0", tx_active_o); end
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] v;
        int n;
        for (int r = 0; r < 4; r++) begin
            clear_mon();
            exp_q.delete();
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) begin
                v = DW'($urandom);
                pulse(v);
                exp_q.push_back(v);
                repeat ($urandom_range(0, 6)) @(posedge clk);
                #1;
            end
            wait_frames(n, n * (FRAME_CLKS + 1) + 60);
            checks++; if (rx_q.size() != n) begin errors++; $display("[TB] FAIL rand%0d_count: got %0d exp %0d", r, rx_q.size(), n); end
            for (int i = 0; i < n && i < rx_q.size(); i++) begin
                checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL rand%0d_data%0d: got %h exp %h", r, i, rx_q[i], exp_q[i]); end
`ifdef LFSR_TX_PARITY_EN
                checks++; if (par_q[i] !== ^exp_q[i]) begin errors++; $display("[TB] FAIL rand%0d_parity%0d: got %b exp %b", r, i, par_q[i], ^exp_q[i]); end
`endif
            end
            checks++; if (line_errs != 0) begin errors++; $display("[TB] FAIL rand%0d_line: got %0d bad samples exp 0", r, line_errs); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int cap_cyc;
        int k;
        logic [DW-1:0] v1;
        clear_mon();
        v1 = DW'($urandom) & 8'hF7;
        pulse(v1);
        cap_cyc = cyc;
        pulse(DW'($urandom));
        k = 0;
        while (cyc < cap_cyc + 18 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        @(negedge clk); #1;
        checks++; if (tx_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_bit3: got %b exp 0", tx_o); end
        rst_n = 1'b0;
        #1;
        checks++; if (tx_o !== 1'b1) begin errors++; $display("[TB] FAIL midrst_tx: got %b exp 1", tx_o); end
        checks++; if (tx_active_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_active: got %b exp 0", tx_active_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_overflow: got %b exp 0", overflow_o); end
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        rst_n = 1'b1;
        clear_mon();
        repeat (2 * FRAME_CLKS) @(posedge clk);
        #1;
        checks++; if (start_q.size() != 0) begin errors++; $display("[TB] FAIL midrst_residual: got %0d frames exp 0", start_q.size()); end
        checks++; if (tx_o !== 1'b1) begin errors++; $display("[TB] FAIL midrst_idle: got %b exp 1", tx_o); end
        checks++; if (line_errs != 0) begin errors++; $display("[TB] FAIL midrst_line: got %0d bad samples exp 0", line_errs); end
    endtask

`ifdef LFSR_TX_PARITY_EN
    task automatic test_parity();
        clear_mon();
        pulse(8'h07);
        wait_frames(1, FRAME_CLKS + 20);
        checks++; if (rx_q.size() != 1) begin errors++; $display("[TB] FAIL parity_count: got %0d exp 1", rx_q.size()); end
        if (rx_q.size() >= 1) begin
            checks++; if (rx_q[0] !== 8'h07) begin errors++; $display("[TB] FAIL parity_data: got %h exp 07", rx_q[0]); end
            checks++; if (par_q[0] !== 1'b1) begin errors++; $display("[TB] FAIL parity_bit: got %b exp 1", par_q[0]); end
            checks++; if (end_q[0] - start_q[0] + 1 != 44) begin errors++; $display("[TB] FAIL parity_length: got %0d exp 44", end_q[0] - start_q[0] + 1); end
        end
        checks++; if (line_errs != 0) begin errors++; $display("[TB] FAIL parity_line: got %0d bad samples exp 0", line_errs); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_no_capture();
        test_random();
        test_reset_mid_frame();
`ifdef LFSR_TX_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout exp completion");
        $fatal(1, "[TB] watchdog");
    end

endmodule
